// File: rtl/deck_dealer.sv
// deck_dealer: 52-card deck dealer with background staging of the next card.
// Serves getCard rising edges with 1-cycle latency and deals each card once.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   shuffle    in   level; refills the deck, discards requests while high
//   getCard    in   card request, rising edge = one request
//   cardOut    out  [5:4] suit 0..3, [3:0] rank 1..13, 0 = no card
//   cardValid  out  one-cycle pulse on each new card
//   emptyErr   out  one-cycle pulse: request while the deck is empty
//   ready      out  a staged card is available
//   cardsLeft  out  undealt cards remaining, 0..52
//   deckEmpty  out  high when cardsLeft == 0
//
// Build option: define DECK_FIXED_ORDER_EN to always start the search at
// index 0, so cards come out in index order 0..51 (LFSR kept but unused).
module deck_dealer #(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shuffle,
    input  logic       getCard,
    output logic [5:0] cardOut,
    output logic       cardValid,
    output logic       emptyErr,
    output logic       ready,
    output logic [5:0] cardsLeft,
    output logic       deckEmpty
);

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        READY = 2'd1,
        EMPTY = 2'd2
    } state_t;

`ifdef DECK_FIXED_ORDER_EN
    localparam logic [5:0] SEED_START = 6'd0;
`else
    localparam logic [5:0] SEED_START =
        (LFSR_SEED[5:0] >= 6'd52) ? LFSR_SEED[5:0] - 6'd52 : LFSR_SEED[5:0];
`endif

    state_t      state;
    logic [7:0]  lfsr;
    logic [51:0] bitmap;
    logic [5:0]  ptr;
    logic [5:0]  staged;
    logic        pending;
    logic        getCard_d;
    logic        req;
    logic        fb;
    logic [5:0]  start;

    // x^8 + x^6 + x^5 + x^4 + 1, maximal length, never reaches zero
    assign fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign req = getCard & ~getCard_d;

`ifdef DECK_FIXED_ORDER_EN
    assign start = 6'd0;
`else
    // fold the 6-bit LFSR slice into 0..51
    assign start = (lfsr[5:0] >= 6'd52) ? lfsr[5:0] - 6'd52 : lfsr[5:0];
`endif

    function automatic logic [5:0] encode(input logic [5:0] idx);
        logic [1:0] s;
        logic [5:0] r;
        if (idx < 6'd13) begin
            s = 2'd0;
            r = idx;
        end else if (idx < 6'd26) begin
            s = 2'd1;
            r = idx - 6'd13;
        end else if (idx < 6'd39) begin
            s = 2'd2;
            r = idx - 6'd26;
        end else begin
            s = 2'd3;
            r = idx - 6'd39;
        end
        encode = {s, 4'(r + 6'd1)};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEEK;
            lfsr      <= LFSR_SEED;
            bitmap    <= '0;
            ptr       <= SEED_START;
            staged    <= 6'd0;
            pending   <= 1'b0;
            getCard_d <= 1'b0;
            cardOut   <= 6'd0;
            cardValid <= 1'b0;
            emptyErr  <= 1'b0;
            ready     <= 1'b0;
            cardsLeft <= 6'd52;
            deckEmpty <= 1'b0;
        end else begin
            lfsr      <= {lfsr[6:0], fb};
            getCard_d <= getCard;
            cardValid <= 1'b0;
            emptyErr  <= 1'b0;
            if (shuffle) begin
                // refill; any request seen now is dropped
                bitmap    <= '0;
                pending   <= 1'b0;
                cardsLeft <= 6'd52;
                deckEmpty <= 1'b0;
                ready     <= 1'b0;
                state     <= SEEK;
                ptr       <= start;
            end else begin
                unique case (state)
                    SEEK: begin
                        if (req)
                            pending <= 1'b1;
                        if (!bitmap[ptr]) begin
                            staged <= ptr;
                            ready  <= 1'b1;
                            state  <= READY;
                        end else begin
                            ptr <= (ptr == 6'd51) ? 6'd0 : ptr + 6'd1;
                        end
                    end
                    READY: begin
                        if (req || pending) begin
                            cardOut        <= encode(staged);
                            cardValid      <= 1'b1;
                            bitmap[staged] <= 1'b1;
                            cardsLeft      <= cardsLeft - 6'd1;
                            pending        <= 1'b0;
                            ready          <= 1'b0;
                            if (cardsLeft == 6'd1) begin
                                deckEmpty <= 1'b1;
                                state     <= EMPTY;
                            end else begin
                                ptr   <= start;
                                state <= SEEK;
                            end
                        end
                    end
                    EMPTY: begin
                        if (req) begin
                            emptyErr <= 1'b1;
                            cardOut  <= 6'd0;
                        end
                    end
                    default: state <= SEEK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deck_dealer.sv
// tb_deck_dealer: directed self-checking bench for deck_dealer.
// Vector table for empty/shuffle corners plus hand-written sequences.
module tb_deck_dealer;

    logic       clk = 1'b0;
    logic       reset;
    logic       shuffle;
    logic       getCard;
    logic [5:0] cardOut;
    logic       cardValid;
    logic       emptyErr;
    logic       ready;
    logic [5:0] cardsLeft;
    logic       deckEmpty;

    deck_dealer #(.LFSR_SEED(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .shuffle   (shuffle),
        .getCard   (getCard),
        .cardOut   (cardOut),
        .cardValid (cardValid),
        .emptyErr  (emptyErr),
        .ready     (ready),
        .cardsLeft (cardsLeft),
        .deckEmpty (deckEmpty)
    );

    always #5 clk = ~clk;

`ifdef DECK_FIXED_ORDER_EN
    localparam logic [5:0] FIRST = 6'h01;
`else
    // seed A5 -> start index 37 -> suit 2, rank 12
    localparam logic [5:0] FIRST = 6'h2C;
`endif

    typedef struct {
        logic       shuf;
        logic       req;
        logic [5:0] left;
        logic       valid;
        logic       err;
        logic       empty;
    } vec_t;

    vec_t tbl [7];
    logic seen [64];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] enc(input int i);
        return {2'(i / 13), 4'(i % 13 + 1)};
    endfunction

    task automatic clear_seen();
        foreach (seen[k]) seen[k] = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic deal(output logic v, output logic [5:0] c);
        wait_ready();
        @(negedge clk);
        getCard = 1'b1;
        @(posedge clk);
        #1;
        v = cardValid;
        c = cardOut;
        @(negedge clk);
        getCard = 1'b0;
    endtask

    task automatic run_deck(input int n, input int base,
                            output logic [5:0] last);
        logic       v;
        logic [5:0] c;
        last = 6'd0;
        for (int i = 0; i < n; i++) begin
            deal(v, c);
            chk("deal_valid", v, 1);
            chk("deal_left", cardsLeft, 51 - (base + i));
            chk("deal_rank", (c[3:0] >= 4'd1 && c[3:0] <= 4'd13), 1);
            chk("deal_dup", seen[c], 0);
            seen[c] = 1'b1;
`ifdef DECK_FIXED_ORDER_EN
            chk("deal_order", c, enc(base + i));
`endif
            last = c;
        end
    endtask

    task automatic shuffle_pulse();
        @(negedge clk);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       v;
        logic [5:0] c;
        logic [5:0] last;
        int         cnt;

        tbl[0] = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 6'd52, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 6'd51, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 6'd52, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 6'd51, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 6'd50, 1'b1, 1'b0, 1'b0};

        reset   = 1'b1;
        shuffle = 1'b0;
        getCard = 1'b0;
        clear_seen();
        repeat (2) @(negedge clk);
        chk("rst_cardOut", cardOut, 0);
        chk("rst_valid", cardValid, 0);
        chk("rst_err", emptyErr, 0);
        chk("rst_ready", ready, 0);
        chk("rst_left", cardsLeft, 52);
        chk("rst_empty", deckEmpty, 0);

        // first card: staged on the first edge, served one edge after request
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_ready", ready, 1);
        deal(v, c);
        chk("first_valid", v, 1);
        chk("first_card", c, FIRST);
        chk("first_left", cardsLeft, 51);
        seen[c] = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_pulse", cardValid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("cardOut_hold", cardOut, FIRST);

        run_deck(51, 1, last);
`ifdef DECK_FIXED_ORDER_EN
        chk("last_card", last, 6'h3D);
`endif
        cnt = 0;
        foreach (seen[k]) if (seen[k]) cnt++;
        chk("distinct52", cnt, 52);
        chk("deck_empty", deckEmpty, 1);
        chk("empty_ready", ready, 0);

        // empty-deck errors, shuffle refill, request discarded by shuffle
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].valid) wait_ready();
            @(negedge clk);
            shuffle = tbl[i].shuf;
            getCard = tbl[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), cardValid, tbl[i].valid);
            chk($sformatf("tbl%0d_err", i), emptyErr, tbl[i].err);
            chk($sformatf("tbl%0d_left", i), cardsLeft, tbl[i].left);
            chk($sformatf("tbl%0d_empty", i), deckEmpty, tbl[i].empty);
            if (tbl[i].err) chk($sformatf("tbl%0d_card0", i), cardOut, 0);
            @(negedge clk);
            shuffle = 1'b0;
            getCard = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("err_pulse", emptyErr, 0);

        // 20 deals, then shuffle together with a request
        shuffle_pulse();
        clear_seen();
        run_deck(20, 0, last);
        @(negedge clk);
        shuffle = 1'b1;
        getCard = 1'b1;
        @(posedge clk);
        #1;
        chk("shuf_req_valid", cardValid, 0);
        chk("shuf_req_left", cardsLeft, 52);
        chk("shuf_keeps_card", cardOut, last);
        @(negedge clk);
        shuffle = 1'b0;
        getCard = 1'b0;
        clear_seen();
        run_deck(52, 0, last);
        chk("deck2_empty", deckEmpty, 1);

        // request while seeking is held pending, served once
        shuffle_pulse();
        getCard = 1'b1;
        @(posedge clk);
        #1;
        chk("pend_ready", ready, 1);
        chk("pend_nodeal", cardValid, 0);
        @(posedge clk);
        #1;
        chk("pend_valid", cardValid, 1);
        chk("pend_left", cardsLeft, 51);
`ifdef DECK_FIXED_ORDER_EN
        chk("pend_card", cardOut, 6'h01);
`endif
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (cardValid) cnt++;
        end
        chk("held_no_extra", cnt, 0);

        // async reset with a request pending
        getCard = 1'b0;
        shuffle_pulse();
        getCard = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_cardOut", cardOut, 0);
        chk("areset_ready", ready, 0);
        chk("areset_left", cardsLeft, 52);
        chk("areset_valid", cardValid, 0);
        getCard = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (cardValid) cnt++;
        end
        chk("post_reset_nodeal", cnt, 0);
        chk("post_reset_ready", ready, 1);
        deal(v, c);
        chk("post_reset_card", c, FIRST);
        chk("post_reset_left", cardsLeft, 51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
